// File: rtl/cache_pkg.sv
// Shared types and constants for the 2-way set-associative write-through data cache.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cache_pkg;

  localparam int SETS  = 64;
  localparam int TAG_W = 10;
  localparam int IDX_W = $clog2(SETS);

  // Byte-address field positions: word select, set index, tag.
  localparam int WORD_BIT  = 2;
  localparam int INDEX_LSB = 3;
  localparam int TAG_LSB   = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL0 = 2'd1,
    FILL1 = 2'd2,
    WRITE = 2'd3
  } state_t;

  // Address of word 0 of the line containing a.
  function automatic logic [31:0] line_base(input logic [31:0] a);
    return a & ~32'h7;
  endfunction

endpackage

// File: rtl/cache_way_array.sv
// One way of the cache: valid bits, tags and two data words per set.
// Latency: lookup is combinational; writes land on the next clk edge.
// Backpressure: none; the controller decides when to write.
// Ports: clk/rst (async active-low, clears valid only), i_index/i_tag/i_word lookup,
//        o_valid/o_hit/o_rdata lookup result, i_we_word/i_wr_word/i_wdata word write,
//        i_we_tag writes the tag and sets valid for i_index.
module cache_way_array
  import cache_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] i_index,
  input  logic [TAG_W-1:0] i_tag,
  input  logic             i_word,
  output logic             o_valid,
  output logic             o_hit,
  output logic [31:0]      o_rdata,
  input  logic             i_we_word,
  input  logic             i_wr_word,
  input  logic [31:0]      i_wdata,
  input  logic             i_we_tag
);

  logic [SETS-1:0]  r_valid;
  logic [TAG_W-1:0] r_tag   [SETS];
  logic [31:0]      r_word0 [SETS];
  logic [31:0]      r_word1 [SETS];

  assign o_valid = r_valid[i_index];
  assign o_hit   = o_valid && (r_tag[i_index] == i_tag);
  assign o_rdata = i_word ? r_word1[i_index] : r_word0[i_index];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= '0;
    end else if (i_we_tag) begin
      r_valid[i_index] <= 1'b1;
    end
  end

  // Tag and data storage carry no reset; valid alone qualifies them.
  always_ff @(posedge clk) begin
    if (i_we_tag) begin
      r_tag[i_index] <= i_tag;
    end
    if (i_we_word && !i_wr_word) begin
      r_word0[i_index] <= i_wdata;
    end
    if (i_we_word && i_wr_word) begin
      r_word1[i_index] <= i_wdata;
    end
  end

endmodule

// File: rtl/cache_controller.sv
// Data cache between MEM stage and SRAM controller: 2-way, 64 sets, 8-byte lines, write-through, no-write-allocate.
// Latency: read hit 0 cycles; read miss = two SRAM word reads + 1; write = one SRAM write.
// Backpressure: ready low freezes the pipeline; SRAM enables are held until sram_ready is sampled high.
// Ports: clk/rst (async active-low); mem_r_en/mem_w_en/address/wdata request, rdata/ready response;
//        sram_read_en/sram_write_en/sram_address/sram_wdata to SRAM controller, sram_rdata/sram_ready back.
module cache_controller
  import cache_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_r_en,
  input  logic        mem_w_en,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        sram_read_en,
  output logic        sram_write_en,
  output logic [31:0] sram_address,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata,
  input  logic        sram_ready
);

  logic             w_rd_req;
  logic             w_wr_req;
  logic [IDX_W-1:0] w_index;
  logic [TAG_W-1:0] w_tag;
  logic             w_word;
  logic [1:0]       w_valid;
  logic [1:0]       w_hit;
  logic             w_hit_any;
  logic             w_hit_way;
  logic             w_victim;
  logic [31:0]      w_way_rdata [2];
  logic [1:0]       w_we_word;
  logic [1:0]       w_we_tag;
  logic             w_wr_word;
  logic [31:0]      w_way_wdata;
  logic             w_fill_done;
  logic             w_write_done;

  state_t           r_state;
  logic             r_victim;
  logic [SETS-1:0]  r_lru;          // per set: the way to replace next
  logic             r_sram_read_en;
  logic             r_sram_write_en;
  logic [31:0]      r_sram_address;
  logic [31:0]      r_sram_wdata;

  // Both enables together count as a write.
  assign w_wr_req  = mem_w_en;
  assign w_rd_req  = mem_r_en && !mem_w_en;
  assign w_index   = address[INDEX_LSB +: IDX_W];
  assign w_tag     = address[TAG_LSB +: TAG_W];
  assign w_word    = address[WORD_BIT];
  assign w_hit_any = |w_hit;
  assign w_hit_way = w_hit[1];
  assign w_victim  = !w_valid[0] ? 1'b0 : (!w_valid[1] ? 1'b1 : r_lru[w_index]);

  // sram_ready only counts while we are driving the matching enable.
  assign w_fill_done  = r_sram_read_en && sram_ready;
  assign w_write_done = r_sram_write_en && sram_ready;

  assign sram_read_en  = r_sram_read_en;
  assign sram_write_en = r_sram_write_en;
  assign sram_address  = r_sram_address;
  assign sram_wdata    = r_sram_wdata;

  for (genvar g = 0; g < 2; g++) begin : g_way
    cache_way_array u_way (
      .clk       (clk),
      .rst       (rst),
      .i_index   (w_index),
      .i_tag     (w_tag),
      .i_word    (w_word),
      .o_valid   (w_valid[g]),
      .o_hit     (w_hit[g]),
      .o_rdata   (w_way_rdata[g]),
      .i_we_word (w_we_word[g]),
      .i_wr_word (w_wr_word),
      .i_wdata   (w_way_wdata),
      .i_we_tag  (w_we_tag[g])
    );
  end

  // Array write port: fills go to the latched victim, store hits update the hit way.
  always_comb begin
    w_we_word   = 2'b00;
    w_we_tag    = 2'b00;
    w_wr_word   = w_word;
    w_way_wdata = r_sram_wdata;
    case (r_state)
      FILL0: begin
        w_wr_word   = 1'b0;
        w_way_wdata = sram_rdata;
        if (w_fill_done) w_we_word[r_victim] = 1'b1;
      end
      FILL1: begin
        w_wr_word   = 1'b1;
        w_way_wdata = sram_rdata;
        if (w_fill_done) begin
          w_we_word[r_victim] = 1'b1;
          w_we_tag[r_victim]  = 1'b1;
        end
      end
      WRITE: begin
        if (w_write_done) w_we_word = w_hit;
      end
      default: ;
    endcase
  end

  // Response side is combinational so read hits finish in the request cycle.
  always_comb begin
    ready = 1'b0;
    rdata = '0;
    case (r_state)
      IDLE: begin
        if (w_wr_req) begin
          ready = 1'b0;
        end else if (w_rd_req) begin
          ready = w_hit_any;
          if (w_hit_any) rdata = w_way_rdata[w_hit_way];
        end else begin
          ready = 1'b1;
        end
      end
      WRITE:   ready = w_write_done;
      default: ready = 1'b0;
    endcase
    // While held in reset the block looks idle, even with a request pending.
    if (!rst) begin
      ready = 1'b1;
      rdata = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state         <= IDLE;
      r_victim        <= 1'b0;
      r_lru           <= '0;
      r_sram_read_en  <= 1'b0;
      r_sram_write_en <= 1'b0;
      r_sram_address  <= '0;
      r_sram_wdata    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_wr_req) begin
            r_sram_write_en <= 1'b1;
            r_sram_address  <= address;
            r_sram_wdata    <= wdata;
            r_state         <= WRITE;
          end else if (w_rd_req) begin
            if (w_hit_any) begin
              r_lru[w_index] <= ~w_hit_way;
            end else begin
              r_victim       <= w_victim;
              r_sram_read_en <= 1'b1;
              r_sram_address <= line_base(address);
              r_state        <= FILL0;
            end
          end
        end
        FILL0: begin
          // Read enable stays up; only the address steps to the second word.
          if (w_fill_done) begin
            r_sram_address <= line_base(address) + 32'd4;
            r_state        <= FILL1;
          end
        end
        FILL1: begin
          if (w_fill_done) begin
            r_sram_read_en <= 1'b0;
            r_lru[w_index] <= ~r_victim;
            r_state        <= IDLE;
          end
        end
        WRITE: begin
          if (w_write_done) begin
            r_sram_write_en <= 1'b0;
            if (w_hit_any) r_lru[w_index] <= ~w_hit_way;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_controller.sv
module tb_cache_controller;

  localparam int SRAM_LAT = 2;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_r_en = 1'b0;
  logic        mem_w_en = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        ready;
  logic        sram_read_en;
  logic        sram_write_en;
  logic [31:0] sram_address;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata = '0;
  logic        sram_ready = 1'b0;

  int          errors = 0;
  int          checks = 0;
  txn_t        exp_sram [$];
  logic [31:0] exp_rd [$];
  logic [31:0] smem [logic [31:0]];
  logic        toggle_idle = 1'b0;
  int          m_cnt = 0;
  txn_t        m_t;
  txn_t        m_e;

  always #5 clk = ~clk;

  cache_controller dut (
    .clk           (clk),
    .rst           (rst),
    .mem_r_en      (mem_r_en),
    .mem_w_en      (mem_w_en),
    .address       (address),
    .wdata         (wdata),
    .rdata         (rdata),
    .ready         (ready),
    .sram_read_en  (sram_read_en),
    .sram_write_en (sram_write_en),
    .sram_address  (sram_address),
    .sram_wdata    (sram_wdata),
    .sram_rdata    (sram_rdata),
    .sram_ready    (sram_ready)
  );

  function automatic logic [31:0] pat(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  function automatic logic [31:0] sram_val(input logic [31:0] a);
    if (smem.exists(a)) return smem[a];
    return pat(a);
  endfunction

  // SRAM model and scoreboard: each completed access is checked against the expected queue.
  always @(negedge clk) begin
    if (!rst) begin
      sram_ready = 1'b0;
      m_cnt = 0;
    end else if (sram_ready) begin
      sram_ready = 1'b0;
      m_cnt = 0;
    end else if (sram_read_en || sram_write_en) begin
      m_cnt++;
      if (m_cnt >= SRAM_LAT) begin
        sram_ready = 1'b1;
        if (sram_write_en) begin
          smem[sram_address] = sram_wdata;
          m_t = '{1'b1, sram_address, sram_wdata};
        end else begin
          sram_rdata = sram_val(sram_address);
          m_t = '{1'b0, sram_address, sram_rdata};
        end
        checks++;
        if (exp_sram.size() == 0) begin
          errors++;
          $display("FAIL sram_txn unexpected got=%h required=none", m_t);
        end else begin
          m_e = exp_sram.pop_front();
          if (m_t !== m_e) begin
            errors++;
            $display("FAIL sram_txn got=%h required=%h", m_t, m_e);
          end
        end
      end
    end else if (toggle_idle) begin
      sram_ready = 1'b1;
    end
  end

  // Drives one request at a negedge and waits (bounded) for ready; returns rdata and wait cycles.
  task automatic do_req(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output int cyc);
    mem_r_en = r;
    mem_w_en = w;
    address  = a;
    wdata    = d;
    cyc = 0;
    #1;
    while (!ready && cyc < 200) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    if (!ready) begin
      checks++;
      errors++;
      $display("FAIL req_timeout addr=%h got ready=%b required=1", a, ready);
    end
    rd = rdata;
    @(negedge clk);
    mem_r_en = 1'b0;
    mem_w_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2;
    checks++;
    if (ready !== 1'b1 || sram_read_en !== 1'b0 || sram_write_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_in got ready=%b rd_en=%b wr_en=%b required 1/0/0", ready, sram_read_en, sram_write_en);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b required=1", ready); end
    checks++;
    if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h required=0", rdata); end
    checks++;
    if (sram_read_en !== 1'b0 || sram_write_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_enables got rd=%b wr=%b required 0/0", sram_read_en, sram_write_en);
    end
    @(negedge clk);
  endtask

  task automatic test_cold_miss();
    logic [31:0] rd, e;
    int cyc;
    smem[32'h400] = 32'h11111111;
    smem[32'h404] = 32'h22222222;
    exp_sram.push_back('{1'b0, 32'h400, 32'h11111111});
    exp_sram.push_back('{1'b0, 32'h404, 32'h22222222});
    exp_rd.push_back(32'h22222222);
    do_req(1'b1, 1'b0, 32'h404, 32'h0, rd, cyc);
    e = exp_rd.pop_front();
    checks++;
    if (rd !== e) begin errors++; $display("FAIL cold_miss_rdata got=%h required=%h", rd, e); end
    checks++;
    if (cyc == 0) begin errors++; $display("FAIL cold_miss_latency got=%0d required>0", cyc); end
    exp_rd.push_back(32'h11111111);
    do_req(1'b1, 1'b0, 32'h400, 32'h0, rd, cyc);
    e = exp_rd.pop_front();
    checks++;
    if (rd !== e) begin errors++; $display("FAIL cold_hit_rdata got=%h required=%h", rd, e); end
    checks++;
    if (cyc != 0) begin errors++; $display("FAIL cold_hit_latency got=%0d required=0", cyc); end
    checks++;
    if (exp_sram.size() != 0) begin
      errors++; $display("FAIL cold_sram_pending got=%0d required=0", exp_sram.size()); exp_sram.delete();
    end
  endtask

  task automatic test_write_hit();
    logic [31:0] rd, e;
    int cyc;
    exp_sram.push_back('{1'b1, 32'h404, 32'h00020001});
    do_req(1'b0, 1'b1, 32'h404, 32'h00020001, rd, cyc);
    checks++;
    if (cyc == 0) begin errors++; $display("FAIL write_hit_latency got=%0d required>0", cyc); end
    exp_rd.push_back(32'h00020001);
    do_req(1'b1, 1'b0, 32'h404, 32'h0, rd, cyc);
    e = exp_rd.pop_front();
    checks++;
    if (rd !== e) begin errors++; $display("FAIL write_hit_rdata got=%h required=%h", rd, e); end
    checks++;
    if (cyc != 0) begin errors++; $display("FAIL write_hit_reread got=%0d cycles required=0", cyc); end
    checks++;
    if (exp_sram.size() != 0) begin
      errors++; $display("FAIL write_hit_sram_pending got=%0d required=0", exp_sram.size()); exp_sram.delete();
    end
  endtask

  task automatic test_lru();
    logic [31:0] addrs [6] = '{32'h400, 32'h600, 32'h400, 32'h800, 32'h400, 32'h600};
    logic        hits  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] rd, e;
    int cyc;
    for (int i = 0; i < 6; i++) begin
      if (!hits[i]) begin
        exp_sram.push_back('{1'b0, addrs[i], sram_val(addrs[i])});
        exp_sram.push_back('{1'b0, addrs[i] + 32'd4, sram_val(addrs[i] + 32'd4)});
      end
      exp_rd.push_back(sram_val(addrs[i]));
      do_req(1'b1, 1'b0, addrs[i], 32'h0, rd, cyc);
      e = exp_rd.pop_front();
      checks++;
      if (rd !== e) begin errors++; $display("FAIL lru_rdata[%0d] got=%h required=%h", i, rd, e); end
      checks++;
      if ((cyc == 0) !== hits[i]) begin
        errors++; $display("FAIL lru_hit[%0d] addr=%h got hit=%b required=%b", i, addrs[i], cyc == 0, hits[i]);
      end
    end
    checks++;
    if (exp_sram.size() != 0) begin
      errors++; $display("FAIL lru_sram_pending got=%0d required=0", exp_sram.size()); exp_sram.delete();
    end
  endtask

  task automatic test_write_miss();
    logic [31:0] rd, e;
    int cyc;
    // Both enables high is a write.
    exp_sram.push_back('{1'b1, 32'hA08, 32'hDEADBEEF});
    do_req(1'b1, 1'b1, 32'hA08, 32'hDEADBEEF, rd, cyc);
    checks++;
    if (cyc == 0) begin errors++; $display("FAIL write_miss_latency got=%0d required>0", cyc); end
    exp_sram.push_back('{1'b0, 32'hA08, 32'hDEADBEEF});
    exp_sram.push_back('{1'b0, 32'hA0C, pat(32'hA0C)});
    exp_rd.push_back(32'hDEADBEEF);
    do_req(1'b1, 1'b0, 32'hA08, 32'h0, rd, cyc);
    e = exp_rd.pop_front();
    checks++;
    if (rd !== e) begin errors++; $display("FAIL write_miss_rdata got=%h required=%h", rd, e); end
    checks++;
    if (cyc == 0) begin errors++; $display("FAIL write_miss_alloc got hit required miss"); end
    checks++;
    if (exp_sram.size() != 0) begin
      errors++; $display("FAIL write_miss_sram_pending got=%0d required=0", exp_sram.size()); exp_sram.delete();
    end
  endtask

  task automatic test_reset_mid_fill();
    logic [31:0] rd, e;
    int cyc, n;
    exp_sram.push_back('{1'b0, 32'hC00, sram_val(32'hC00)});
    mem_r_en = 1'b1;
    address  = 32'hC00;
    n = 0;
    #1;
    while (!(sram_read_en === 1'b1 && sram_address === 32'hC04) && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (n >= 100) begin errors++; $display("FAIL mid_fill_reach got addr=%h required=00000c04", sram_address); end
    rst = 1'b0;
    #1;
    checks++;
    if (sram_read_en !== 1'b0) begin errors++; $display("FAIL mid_fill_rd_en got=%b required=0", sram_read_en); end
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL mid_fill_ready got=%b required=1", ready); end
    repeat (2) @(negedge clk);
    mem_r_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    exp_sram.push_back('{1'b0, 32'hC00, sram_val(32'hC00)});
    exp_sram.push_back('{1'b0, 32'hC04, sram_val(32'hC04)});
    exp_rd.push_back(sram_val(32'hC00));
    do_req(1'b1, 1'b0, 32'hC00, 32'h0, rd, cyc);
    e = exp_rd.pop_front();
    checks++;
    if (rd !== e) begin errors++; $display("FAIL mid_fill_reread got=%h required=%h", rd, e); end
    checks++;
    if (cyc == 0) begin errors++; $display("FAIL mid_fill_valid got hit required miss"); end
    checks++;
    if (exp_sram.size() != 0) begin
      errors++; $display("FAIL mid_fill_sram_pending got=%0d required=0", exp_sram.size()); exp_sram.delete();
    end
  endtask

  task automatic test_idle();
    logic [31:0] rd, e;
    int cyc;
    // Set 0 holds 0xC00 in way0; filling 0xE00 into way1 leaves way0 as next victim.
    exp_sram.push_back('{1'b0, 32'hE00, sram_val(32'hE00)});
    exp_sram.push_back('{1'b0, 32'hE04, sram_val(32'hE04)});
    do_req(1'b1, 1'b0, 32'hE00, 32'h0, rd, cyc);
    checks++;
    if (cyc == 0) begin errors++; $display("FAIL idle_prep got hit required miss"); end
    toggle_idle = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (ready !== 1'b1 || rdata !== 32'h0 || sram_read_en !== 1'b0 || sram_write_en !== 1'b0) begin
        errors++;
        $display("FAIL idle[%0d] got ready=%b rdata=%h rd_en=%b wr_en=%b required 1/0/0/0",
                 i, ready, rdata, sram_read_en, sram_write_en);
      end
    end
    toggle_idle = 1'b0;
    repeat (2) @(negedge clk);
    // LRU untouched by idle cycles: 0x1000 must evict 0xC00, not 0xE00.
    exp_sram.push_back('{1'b0, 32'h1000, sram_val(32'h1000)});
    exp_sram.push_back('{1'b0, 32'h1004, sram_val(32'h1004)});
    do_req(1'b1, 1'b0, 32'h1000, 32'h0, rd, cyc);
    exp_rd.push_back(pat(32'hE00));
    do_req(1'b1, 1'b0, 32'hE00, 32'h0, rd, cyc);
    e = exp_rd.pop_front();
    checks++;
    if (rd !== e) begin errors++; $display("FAIL idle_lru_rdata got=%h required=%h", rd, e); end
    checks++;
    if (cyc != 0) begin errors++; $display("FAIL idle_lru_hit got=%0d cycles required=0", cyc); end
    checks++;
    if (exp_sram.size() != 0) begin
      errors++; $display("FAIL idle_sram_pending got=%0d required=0", exp_sram.size()); exp_sram.delete();
    end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_write_hit();
    test_lru();
    test_write_miss();
    test_reset_mid_fill();
    test_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog got=timeout required=finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
